// File: rtl/reg_ram_pkg.sv
// reg_ram_pkg
// Shared definitions for the clearable single-port register RAM.
//   reg_ram_state_t : sweep sequencer states (CLEAR, READY)
//   BYTE_W          : width of one byte lane
//   merge_byte()    : byte-lane merge used by the write path and by the
//                     write-first read path, so both see identical data.
package reg_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } reg_ram_state_t;

  localparam int unsigned BYTE_W = 8;

  // Returns the new byte when its enable is set, otherwise the old one.
  function automatic logic [BYTE_W-1:0] merge_byte(
    input logic [BYTE_W-1:0] old_byte,
    input logic [BYTE_W-1:0] new_byte,
    input logic              be
  );
    return be ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/reg_ram_clr_fsm.sv
// reg_ram_clr_fsm
// Clear sequencer for reg_ram1rw_clr. Sweeps every entry once after reset
// or after a clear pulse, then reports the array as ready.
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   clear        in   request a (re)start of the full sweep
//   ready        out  registered; array accepts accesses
//   sweep_we     out  write INIT_VALUE to sweep_addr this cycle
//   sweep_addr   out  entry being cleared (clr_ptr)
//   sweep_active out  sweep owns the array address/data this cycle
module reg_ram_clr_fsm
  import reg_ram_pkg::*;
#(
  parameter int unsigned LG_DEPTH = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  output logic                ready,
  output logic                sweep_we,
  output logic [LG_DEPTH-1:0] sweep_addr,
  output logic                sweep_active
);

  reg_ram_state_t      state_q, state_d;
  logic [LG_DEPTH-1:0] clr_ptr_q, clr_ptr_d;
  logic                ready_q, ready_d;

  // Next-state logic. The pointer wraps naturally to zero after the last
  // entry, and a clear seen mid-sweep simply restarts from entry 0.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ready_d   = ready_q;
    case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + LG_DEPTH'(1);
        if (clear) begin
          clr_ptr_d = '0;
        end else if (&clr_ptr_q) begin
          state_d = READY;
          ready_d = 1'b1;
        end
      end
      READY: begin
        if (clear) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
          ready_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
    end
  end

  assign ready        = ready_q;
  assign sweep_active = (state_q == CLEAR);
  assign sweep_we     = sweep_active;
  assign sweep_addr   = clr_ptr_q;

endmodule

// File: rtl/reg_ram1rw_clr.sv
// reg_ram1rw_clr
// Single-port, byte-enabled register RAM with synchronous read and a
// hardware clear sweep. User accesses are accepted only while ready=1.
// Optional macro REG_RAM_WRITE_FIRST_EN: a same-cycle read and write
// returns the merged new entry; default build returns the old entry.
// Ports:
//   clk, reset (async active-low)
//   clear             start a full sweep writing INIT_VALUE to all entries
//   ready             array accepting accesses (registered)
//   addr, rd_en       read request, data returned on the next edge
//   wr_en, wr_be,     byte-enabled write
//   wr_data
//   rd_data, rd_valid read result and its one-cycle qualifier
module reg_ram1rw_clr
  import reg_ram_pkg::*;
#(
  parameter int unsigned       WIDTH      = 64,
  parameter int unsigned       LG_DEPTH   = 6,
  parameter logic [WIDTH-1:0]  INIT_VALUE = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  output logic                ready,
  input  logic [LG_DEPTH-1:0] addr,
  input  logic                rd_en,
  input  logic                wr_en,
  input  logic [WIDTH/8-1:0]  wr_be,
  input  logic [WIDTH-1:0]    wr_data,
  output logic [WIDTH-1:0]    rd_data,
  output logic                rd_valid
);

  localparam int unsigned DEPTH  = 1 << LG_DEPTH;
  localparam int unsigned NBYTES = WIDTH / BYTE_W;

  logic                sweep_we;
  logic                sweep_active;
  logic [LG_DEPTH-1:0] sweep_addr;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [WIDTH-1:0]    old_entry;
  logic [WIDTH-1:0]    merged;
  logic                rd_acc;
  logic                wr_acc;
  logic                arr_we;
  logic [LG_DEPTH-1:0] arr_addr;
  logic [WIDTH-1:0]    arr_data;

  logic [WIDTH-1:0]    rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;

  reg_ram_clr_fsm #(
    .LG_DEPTH(LG_DEPTH)
  ) u_clr_fsm (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .ready       (ready),
    .sweep_we    (sweep_we),
    .sweep_addr  (sweep_addr),
    .sweep_active(sweep_active)
  );

  // ready is still high in the cycle a clear is sampled, so an access
  // presented alongside the clear pulse is honoured.
  assign rd_acc    = ready & rd_en;
  assign wr_acc    = ready & wr_en;
  assign old_entry = mem_q[addr];

  always_comb begin
    merged = '0;
    for (int i = 0; i < NBYTES; i++) begin
      merged[i*BYTE_W +: BYTE_W] = merge_byte(old_entry[i*BYTE_W +: BYTE_W],
                                              wr_data[i*BYTE_W +: BYTE_W],
                                              wr_be[i]);
    end
  end

  // The sweep owns the array port while active; user writes are blocked
  // then anyway because ready is low.
  always_comb begin
    arr_we   = sweep_we | wr_acc;
    arr_addr = sweep_active ? sweep_addr : addr;
    arr_data = sweep_active ? INIT_VALUE : merged;
  end

  // Array storage is intentionally not reset; the sweep initialises it.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      mem_q[arr_addr] <= arr_data;
    end
  end

  always_comb begin
    rd_valid_d = rd_acc;
    rd_data_d  = rd_data_q;
    if (rd_acc) begin
`ifdef REG_RAM_WRITE_FIRST_EN
      rd_data_d = wr_acc ? merged : old_entry;
`else
      rd_data_d = old_entry;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_reg_ram1rw_clr.sv
// tb_reg_ram1rw_clr
// Self-checking bench for reg_ram1rw_clr (WIDTH=64, LG_DEPTH=4).
// Keeps a plain array model of the entries plus the last returned read
// value; honours REG_RAM_WRITE_FIRST_EN for same-cycle read/write data.
module tb_reg_ram1rw_clr;

  localparam int          W    = 64;
  localparam int          LGD  = 4;
  localparam int          D    = 16;
  localparam int          NB   = 8;
  localparam logic [63:0] INIT = 64'hDEAD_BEEF_0000_0001;
`ifdef REG_RAM_WRITE_FIRST_EN
  localparam bit WF = 1'b1;
`else
  localparam bit WF = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           clear;
  logic           ready;
  logic [LGD-1:0] addr;
  logic           rd_en;
  logic           wr_en;
  logic [NB-1:0]  wr_be;
  logic [W-1:0]   wr_data;
  logic [W-1:0]   rd_data;
  logic           rd_valid;

  logic [W-1:0] model [D];
  logic [W-1:0] last_rd;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  reg_ram1rw_clr #(
    .WIDTH     (W),
    .LG_DEPTH  (LGD),
    .INIT_VALUE(INIT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .ready   (ready),
    .addr    (addr),
    .rd_en   (rd_en),
    .wr_en   (wr_en),
    .wr_be   (wr_be),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .rd_valid(rd_valid)
  );

  function automatic logic [W-1:0] apply_be(input logic [W-1:0] old_v,
                                            input logic [W-1:0] new_v,
                                            input logic [NB-1:0] be);
    logic [W-1:0] r;
    r = old_v;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear   = 1'b0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    addr    = '0;
    wr_be   = '0;
    wr_data = '0;
  endtask

  task automatic model_init();
    for (int i = 0; i < D; i++) model[i] = INIT;
  endtask

  // Counts D edges after a sweep start; ready must appear on exactly the
  // last one and no read may be reported valid meanwhile.
  task automatic check_sweep(input string tag);
    for (int k = 1; k <= D; k++) begin
      tick();
      checks++;
      if (ready !== (k == D)) begin
        errors++;
        $display("[TB] FAIL %s ready cycle %0d: got %b expected %b", tag, k, ready, (k == D));
      end
      checks++;
      if (rd_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s rd_valid cycle %0d: got %b expected 0", tag, k, rd_valid);
      end
    end
    model_init();
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < D; i++) begin
      rd_en = 1'b1;
      addr  = LGD'(i);
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== model[i]) begin
        errors++;
        $display("[TB] FAIL %s entry %0d: got valid=%b data=%h expected valid=1 data=%h",
                 tag, i, rd_valid, rd_data, model[i]);
      end
      last_rd = model[i];
    end
    rd_en = 1'b0;
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== last_rd) begin
      errors++;
      $display("[TB] FAIL %s idle: got valid=%b data=%h expected valid=0 data=%h",
               tag, rd_valid, rd_data, last_rd);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    checks++;
    if (ready !== 1'b0 || rd_valid !== 1'b0 || rd_data !== '0) begin
      errors++;
      $display("[TB] FAIL %s: got ready=%b valid=%b data=%h expected 0/0/0",
               tag, ready, rd_valid, rd_data);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    #12;
    check_zero_outputs("reset_outputs");
    tick();
    reset   = 1'b1;
    last_rd = '0;
    check_sweep("reset_sweep");
    read_all("reset_init_read");
  endtask

  task automatic test_byte_write();
    wr_en   = 1'b1;
    addr    = 4'd3;
    wr_data = 64'h1122_3344_5566_7788;
    wr_be   = 8'h0F;
    tick();
    model[3] = apply_be(model[3], wr_data, wr_be);
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 64'hDEAD_BEEF_5566_7788) begin
      errors++;
      $display("[TB] FAIL byte_write: got valid=%b data=%h expected valid=1 data=%h",
               rd_valid, rd_data, 64'hDEAD_BEEF_5566_7788);
    end
    last_rd = rd_data;
    rd_en   = 1'b0;
  endtask

  task automatic test_same_cycle();
    logic [W-1:0] exp;
    wr_en   = 1'b1;
    addr    = 4'd5;
    wr_data = 64'hA;
    wr_be   = 8'hFF;
    tick();
    model[5] = 64'hA;
    rd_en   = 1'b1;
    wr_data = 64'hB;
    tick();
    exp = WF ? 64'hB : 64'hA;
    model[5] = 64'hB;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp) begin
      errors++;
      $display("[TB] FAIL same_cycle_rw: got valid=%b data=%h expected valid=1 data=%h",
               rd_valid, rd_data, exp);
    end
    wr_en = 1'b0;
    tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 64'hB) begin
      errors++;
      $display("[TB] FAIL same_cycle_reread: got valid=%b data=%h expected valid=1 data=%h",
               rd_valid, rd_data, 64'hB);
    end
    last_rd = 64'hB;
    rd_en   = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] exp;
    logic         rd;
    for (int n = 0; n < 300; n++) begin
      rd      = 1'($urandom_range(0, 1));
      rd_en   = rd;
      wr_en   = 1'($urandom_range(0, 1));
      addr    = LGD'($urandom_range(0, D - 1));
      wr_be   = NB'($urandom);
      wr_data = {$urandom, $urandom};
      exp     = last_rd;
      if (rd) exp = (WF && wr_en) ? apply_be(model[addr], wr_data, wr_be) : model[addr];
      if (wr_en) model[addr] = apply_be(model[addr], wr_data, wr_be);
      tick();
      checks++;
      if (rd_valid !== rd || rd_data !== exp) begin
        errors++;
        $display("[TB] FAIL random %0d: got valid=%b data=%h expected valid=%b data=%h",
                 n, rd_valid, rd_data, rd, exp);
      end
      last_rd = exp;
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    clear = 1'b1;
    rd_en = 1'b1;
    addr  = 4'd2;
    tick();
    checks++;
    if (ready !== 1'b0 || rd_valid !== 1'b1 || rd_data !== model[2]) begin
      errors++;
      $display("[TB] FAIL clear_edge: got ready=%b valid=%b data=%h expected 0/1/%h",
               ready, rd_valid, rd_data, model[2]);
    end
    last_rd = model[2];
    clear   = 1'b0;
    for (int k = 1; k <= D; k++) begin
      rd_en   = 1'b1;
      wr_en   = 1'b1;
      addr    = LGD'($urandom_range(0, D - 1));
      wr_be   = 8'hFF;
      wr_data = {$urandom, $urandom};
      tick();
      checks++;
      if (ready !== (k == D) || rd_valid !== 1'b0 || rd_data !== last_rd) begin
        errors++;
        $display("[TB] FAIL clear_sweep cycle %0d: got ready=%b valid=%b data=%h expected %b/0/%h",
                 k, ready, rd_valid, rd_data, (k == D), last_rd);
      end
    end
    idle_inputs();
    model_init();
    read_all("clear_read");
  endtask

  task automatic test_clear_restart();
    wr_en   = 1'b1;
    addr    = 4'd9;
    wr_be   = 8'hFF;
    wr_data = 64'h0123_4567_89AB_CDEF;
    tick();
    idle_inputs();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL restart_first_sweep cycle %0d: got ready=%b expected 0", k, ready);
      end
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart_edge: got ready=%b expected 0", ready);
    end
    check_sweep("restart_sweep");
    read_all("restart_read");
  endtask

  task automatic test_reset_mid();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    reset = 1'b0;
    #1;
    check_zero_outputs("reset_mid_sweep");
    last_rd = '0;
    tick();
    reset = 1'b1;
    check_sweep("reset_mid_sweep_resweep");
    read_all("reset_mid_sweep_read");

    rd_en = 1'b1;
    addr  = 4'd4;
    tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== model[4]) begin
      errors++;
      $display("[TB] FAIL reset_mid_read_setup: got valid=%b data=%h expected valid=1 data=%h",
               rd_valid, rd_data, model[4]);
    end
    reset = 1'b0;
    #1;
    check_zero_outputs("reset_mid_read");
    last_rd = '0;
    rd_en   = 1'b0;
    tick();
    reset = 1'b1;
    check_sweep("reset_mid_read_resweep");
    read_all("reset_mid_read_read");
  endtask

  initial begin
    last_rd = '0;
    test_reset();
    test_byte_write();
    test_same_cycle();
    test_random();
    test_clear();
    test_clear_restart();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
